// File: rtl/multicycle_cu.sv
// Multicycle LEGv8 control unit: FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath strobes.
// 3-5 cycles per instruction; stalls in FETCH/MEM until ready, halting after WAIT_MAX low cycles.
module multicycle_cu #(
  parameter int OPCODE_W   = 11,
  parameter int WAIT_MAX   = 15,
  parameter bit ENABLE_IMM = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                Zero,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imemRd,
  output logic                irWr,
  output logic                reg2loc,
  output logic [1:0]          seu,
  output logic                aluSrc,
  output logic [2:0]          aluOp,
  output logic                memRd,
  output logic                memWr,
  output logic                memToReg,
  output logic                regWr,
  output logic                pcWr,
  output logic                pcSrc,
  output logic [2:0]          state_o,
  output logic                illegal,
  output logic                timeout
);

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [9:0]  OP_ANDI = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI = 10'b1011001000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  WAIT_LAST = 8'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd7
  } state_t;

  typedef enum logic [2:0] {CL_NONE, CL_R, CL_I, CL_D, CL_B, CL_CB} class_t;

  state_t              state, nextState;
  logic [OPCODE_W-1:0] opQ;
  logic [7:0]          waitCnt;
  logic                timeoutQ;
  class_t              opClass;
  logic [2:0]          opAlu;
  logic                isLdur, isCbnz, cbTaken;
  logic                inWait, waitRdy, waitExpired;

  // Classification looks only at the latched opcode, widest match first.
  always_comb begin
    opClass = CL_NONE;
    opAlu   = 3'b000;
    if (opQ == OP_ADD) begin
      opClass = CL_R; opAlu = 3'b000;
    end else if (opQ == OP_SUB) begin
      opClass = CL_R; opAlu = 3'b001;
    end else if (opQ == OP_AND) begin
      opClass = CL_R; opAlu = 3'b010;
    end else if (opQ == OP_ORR) begin
      opClass = CL_R; opAlu = 3'b011;
    end else if (opQ == OP_LDUR || opQ == OP_STUR) begin
      opClass = CL_D;
    end else if (ENABLE_IMM && opQ[10:1] == OP_ADDI) begin
      opClass = CL_I; opAlu = 3'b000;
    end else if (ENABLE_IMM && opQ[10:1] == OP_SUBI) begin
      opClass = CL_I; opAlu = 3'b001;
    end else if (ENABLE_IMM && opQ[10:1] == OP_ANDI) begin
      opClass = CL_I; opAlu = 3'b010;
    end else if (ENABLE_IMM && opQ[10:1] == OP_ORRI) begin
      opClass = CL_I; opAlu = 3'b011;
    end else if (opQ[10:3] == OP_CBZ || opQ[10:3] == OP_CBNZ) begin
      opClass = CL_CB;
    end else if (opQ[10:5] == OP_B) begin
      opClass = CL_B;
    end
  end

  assign isLdur      = (opQ == OP_LDUR);
  assign isCbnz      = (opQ[10:3] == OP_CBNZ);
  assign cbTaken     = isCbnz ? !Zero : Zero;
  assign inWait      = (state == FETCH) || (state == MEM);
  assign waitRdy     = (state == MEM) ? dmem_ready : imem_ready;
  // A ready arriving on the last allowed cycle still wins.
  assign waitExpired = inWait && !waitRdy && (waitCnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      opQ      <= '0;
      waitCnt  <= '0;
      timeoutQ <= 1'b0;
    end else begin
      state <= nextState;
      if (state == FETCH && imem_ready) opQ <= opcode;
      if (inWait && !waitRdy) waitCnt <= waitCnt + 8'd1;
      else                    waitCnt <= '0;
      if (waitExpired) timeoutQ <= 1'b1;
    end
  end

  always_comb begin
    nextState = state;
    imemRd    = 1'b0;
    irWr      = 1'b0;
    reg2loc   = 1'b0;
    seu       = 2'b00;
    aluSrc    = 1'b0;
    aluOp     = 3'b000;
    memRd     = 1'b0;
    memWr     = 1'b0;
    memToReg  = 1'b0;
    regWr     = 1'b0;
    pcWr      = 1'b0;
    pcSrc     = 1'b0;
    illegal   = 1'b0;
    case (state)
      FETCH: begin
        imemRd = 1'b1;
        if (imem_ready) begin
          irWr = 1'b1; pcWr = 1'b1; nextState = DECODE;
        end else if (waitExpired) begin
          nextState = HALT;
        end
      end
      DECODE: begin
        if (opClass == CL_NONE) begin
          illegal = 1'b1; nextState = FETCH;
        end else begin
          nextState = EXEC;
        end
      end
      EXEC: begin
        nextState = FETCH;
        case (opClass)
          CL_R: begin
            aluOp = opAlu; nextState = WB;
          end
          CL_I: begin
            reg2loc = 1'b1; seu = 2'b00; aluSrc = 1'b1; aluOp = opAlu; nextState = WB;
          end
          CL_D: begin
            reg2loc = 1'b1; seu = 2'b01; aluSrc = 1'b1; nextState = MEM;
          end
          CL_B: begin
            seu = 2'b10; pcWr = 1'b1; pcSrc = 1'b1;
          end
          CL_CB: begin
            reg2loc = 1'b1; seu = 2'b11; aluOp = 3'b100; pcWr = cbTaken; pcSrc = cbTaken;
          end
          default: ;
        endcase
      end
      MEM: begin
        seu    = 2'b01;
        aluSrc = 1'b1;
        memRd  = isLdur;
        memWr  = !isLdur;
        if (dmem_ready)       nextState = isLdur ? WB : FETCH;
        else if (waitExpired) nextState = HALT;
      end
      WB: begin
        regWr = 1'b1; memToReg = isLdur; nextState = FETCH;
      end
      HALT: ;
      default: nextState = FETCH;
    endcase
    // Strobes stay quiet for as long as reset is held, whatever the state register says.
    if (reset) begin
      imemRd = 1'b0; irWr = 1'b0; memRd = 1'b0; memWr = 1'b0;
      regWr  = 1'b0; pcWr = 1'b0; illegal = 1'b0;
    end
  end

  assign state_o = state;
  assign timeout = timeoutQ;

endmodule

// File: tb/tb_multicycle_cu.sv
// Scoreboard bench for multicycle_cu: per-instruction cycle scripts from a class-level model,
// checked every cycle by a decoupled monitor; a second instance runs with immediates disabled.
module tb_multicycle_cu;

  localparam int WAIT_MAX = 15;

  typedef enum int {K_R, K_I, K_LD, K_ST, K_B, K_CBZ, K_CBNZ, K_ILL} kind_t;

  typedef struct packed {
    logic [2:0] st;
    logic       imemRd, irWr, reg2loc;
    logic [1:0] seu;
    logic       aluSrc;
    logic [2:0] aluOp;
    logic       memRd, memWr, memToReg, regWr, pcWr, pcSrc, illegal, timeout;
  } obs_t;

  typedef struct {
    int    cyc;
    obs_t  o;
    string tag;
  } exp_t;

  typedef struct {
    string       name;
    logic [10:0] base;
    logic [10:0] mask;
    kind_t       k;
    logic [2:0]  alu;
  } ins_t;

  logic        clk = 1'b0;
  logic        reset, Zero, imem_ready, dmem_ready;
  logic [10:0] opcode;

  logic       imemRd1, irWr1, reg2loc1, aluSrc1, memRd1, memWr1, memToReg1, regWr1, pcWr1, pcSrc1, illegal1, timeout1;
  logic [1:0] seu1;
  logic [2:0] aluOp1, state1;
  logic       imemRd2, irWr2, reg2loc2, aluSrc2, memRd2, memWr2, memToReg2, regWr2, pcWr2, pcSrc2, illegal2, timeout2;
  logic [1:0] seu2;
  logic [2:0] aluOp2, state2;
  obs_t       obs1, obs2;

  multicycle_cu #(.OPCODE_W(11), .WAIT_MAX(WAIT_MAX), .ENABLE_IMM(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .Zero(Zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imemRd(imemRd1), .irWr(irWr1), .reg2loc(reg2loc1), .seu(seu1), .aluSrc(aluSrc1),
    .aluOp(aluOp1), .memRd(memRd1), .memWr(memWr1), .memToReg(memToReg1), .regWr(regWr1),
    .pcWr(pcWr1), .pcSrc(pcSrc1), .state_o(state1), .illegal(illegal1), .timeout(timeout1)
  );

  multicycle_cu #(.OPCODE_W(11), .WAIT_MAX(WAIT_MAX), .ENABLE_IMM(1'b0)) dutNoImm (
    .clk(clk), .reset(reset), .opcode(opcode), .Zero(Zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imemRd(imemRd2), .irWr(irWr2), .reg2loc(reg2loc2), .seu(seu2), .aluSrc(aluSrc2),
    .aluOp(aluOp2), .memRd(memRd2), .memWr(memWr2), .memToReg(memToReg2), .regWr(regWr2),
    .pcWr(pcWr2), .pcSrc(pcSrc2), .state_o(state2), .illegal(illegal2), .timeout(timeout2)
  );

  assign obs1 = {state1, imemRd1, irWr1, reg2loc1, seu1, aluSrc1, aluOp1,
                 memRd1, memWr1, memToReg1, regWr1, pcWr1, pcSrc1, illegal1, timeout1};
  assign obs2 = {state2, imemRd2, irWr2, reg2loc2, seu2, aluSrc2, aluOp2,
                 memRd2, memWr2, memToReg2, regWr2, pcWr2, pcSrc2, illegal2, timeout2};

  always #5 clk = ~clk;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q1[$];
  exp_t q2[$];
  ins_t tbl[16];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares whichever expected records fall due in the current cycle.
  always @(negedge clk) begin
    exp_t h;
    if (q1.size() > 0 && q1[0].cyc == cyc) begin
      h = q1.pop_front();
      checks++;
      if (obs1 !== h.o) begin
        errors++;
        $display("FAIL %s (cycle %0d): got %05h state %0d, expected %05h state %0d",
                 h.tag, cyc, obs1, obs1.st, h.o, h.o.st);
      end
    end
    if (q2.size() > 0 && q2[0].cyc == cyc) begin
      h = q2.pop_front();
      checks++;
      if (obs2 !== h.o) begin
        errors++;
        $display("FAIL %s/noimm (cycle %0d): got %05h state %0d, expected %05h state %0d",
                 h.tag, cyc, obs2, obs2.st, h.o, h.o.st);
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push1(input int c, input obs_t o, input string tag);
    exp_t h;
    h.cyc = c; h.o = o; h.tag = tag;
    q1.push_back(h);
  endtask

  task automatic push2(input int c, input obs_t o, input string tag);
    exp_t h;
    h.cyc = c; h.o = o; h.tag = tag;
    q2.push_back(h);
  endtask

  task automatic setIns(input int i, input string name, input logic [10:0] base,
                        input logic [10:0] mask, input kind_t k, input logic [2:0] alu);
    tbl[i].name = name; tbl[i].base = base; tbl[i].mask = mask; tbl[i].k = k; tbl[i].alu = alu;
  endtask

  // Reset held across two edges; the cycle between them must show a quiet FETCH with timeout clear.
  task automatic resetSeq(input string tag);
    obs_t e;
    reset = 1'b1; imem_ready = rb(); dmem_ready = rb(); Zero = rb(); opcode = 11'($urandom);
    @(posedge clk); #1;
    e = '0;
    push1(cyc, e, tag);
    push2(cyc, e, tag);
    imem_ready = rb(); dmem_ready = rb();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Builds the expected cycle script of one instruction from its class, then plays it.
  // iw/dw: low cycles before imem/dmem ready (>= WAIT_MAX means never ready).
  task automatic runInstr(input string tag, input logic [10:0] op, input kind_t k, input logic [2:0] alu,
                          input logic z, input int iw, input int dw, input int rstAt, input bit dual);
    logic ir[$];
    logic dr[$];
    logic zq[$];
    obs_t ex[$];
    obs_t e;
    logic taken;
    bit   halted;
    int   nf, nm, c0;
    halted = (iw >= WAIT_MAX);
    nf = halted ? WAIT_MAX : iw + 1;
    for (int i = 0; i < nf; i++) begin
      e = '0; e.st = 3'd0; e.imemRd = 1'b1;
      if (!halted && i == iw) begin e.irWr = 1'b1; e.pcWr = 1'b1; end
      ex.push_back(e); ir.push_back(!halted && i == iw); dr.push_back(rb()); zq.push_back(rb());
    end
    if (!halted) begin
      e = '0; e.st = 3'd1; e.illegal = (k == K_ILL);
      ex.push_back(e); ir.push_back(rb()); dr.push_back(rb()); zq.push_back(rb());
      if (k != K_ILL) begin
        e = '0; e.st = 3'd2;
        taken = (k == K_CBZ && z) || (k == K_CBNZ && !z);
        case (k)
          K_R:         e.aluOp = alu;
          K_I:         begin e.reg2loc = 1'b1; e.aluSrc = 1'b1; e.aluOp = alu; end
          K_LD, K_ST:  begin e.reg2loc = 1'b1; e.seu = 2'b01; e.aluSrc = 1'b1; end
          K_B:         begin e.seu = 2'b10; e.pcWr = 1'b1; e.pcSrc = 1'b1; end
          default:     begin e.reg2loc = 1'b1; e.seu = 2'b11; e.aluOp = 3'b100; e.pcWr = taken; e.pcSrc = taken; end
        endcase
        ex.push_back(e); ir.push_back(rb()); dr.push_back(rb()); zq.push_back(z);
        if (k == K_LD || k == K_ST) begin
          halted = (dw >= WAIT_MAX);
          nm = halted ? WAIT_MAX : dw + 1;
          for (int i = 0; i < nm; i++) begin
            e = '0; e.st = 3'd3; e.seu = 2'b01; e.aluSrc = 1'b1;
            e.memRd = (k == K_LD); e.memWr = (k == K_ST);
            ex.push_back(e); ir.push_back(rb()); dr.push_back(!halted && i == dw); zq.push_back(rb());
          end
        end
        if (!halted && (k == K_R || k == K_I || k == K_LD)) begin
          e = '0; e.st = 3'd4; e.regWr = 1'b1; e.memToReg = (k == K_LD);
          ex.push_back(e); ir.push_back(rb()); dr.push_back(rb()); zq.push_back(rb());
        end
      end
    end
    if (halted) begin
      for (int i = 0; i < 3; i++) begin
        e = '0; e.st = 3'd7; e.timeout = 1'b1;
        ex.push_back(e); ir.push_back(rb()); dr.push_back(rb()); zq.push_back(rb());
      end
    end

    c0 = cyc;
    for (int i = 0; i < ex.size(); i++)
      if (rstAt < 0 || i < rstAt) push1(c0 + i, ex[i], tag);
    if (dual) begin
      for (int i = 0; i <= iw; i++) push2(c0 + i, ex[i], tag);
      e = '0; e.st = 3'd1; e.illegal = 1'b1;
      push2(c0 + iw + 1, e, tag);
      e = '0; e.imemRd = 1'b1; e.irWr = ir[iw + 2]; e.pcWr = ir[iw + 2];
      push2(c0 + iw + 2, e, tag);
    end

    for (int i = 0; i < ex.size(); i++) begin
      imem_ready = ir[i]; dmem_ready = dr[i]; Zero = zq[i];
      opcode = (i == iw) ? op : 11'($urandom);
      if (i == rstAt) reset = 1'b1;
      @(posedge clk); #1;
      if (i == rstAt) begin
        reset = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    int idx, iw, dw;
    logic [10:0] op;
    setIns(0,  "add",  11'b10001011000, 11'h000, K_R,    3'd0);
    setIns(1,  "sub",  11'b11001011000, 11'h000, K_R,    3'd1);
    setIns(2,  "and",  11'b10001010000, 11'h000, K_R,    3'd2);
    setIns(3,  "orr",  11'b10101010000, 11'h000, K_R,    3'd3);
    setIns(4,  "addi", 11'b10010001000, 11'h001, K_I,    3'd0);
    setIns(5,  "subi", 11'b11010001000, 11'h001, K_I,    3'd1);
    setIns(6,  "andi", 11'b10010010000, 11'h001, K_I,    3'd2);
    setIns(7,  "orri", 11'b10110010000, 11'h001, K_I,    3'd3);
    setIns(8,  "ldur", 11'b11111000010, 11'h000, K_LD,   3'd0);
    setIns(9,  "stur", 11'b11111000000, 11'h000, K_ST,   3'd0);
    setIns(10, "b",    11'b00010100000, 11'h01F, K_B,    3'd0);
    setIns(11, "cbz",  11'b10110100000, 11'h007, K_CBZ,  3'd4);
    setIns(12, "cbnz", 11'b10110101000, 11'h007, K_CBNZ, 3'd4);
    setIns(13, "ill0", 11'b00000000000, 11'h000, K_ILL,  3'd0);
    setIns(14, "ill1", 11'b11111111111, 11'h000, K_ILL,  3'd0);
    setIns(15, "ill2", 11'b10001011001, 11'h000, K_ILL,  3'd0);

    resetSeq("reset_state");
    runInstr("add_noWait",   11'b10001011000, K_R,    3'd0, 1'b0, 0, 0, -1, 1'b0);
    runInstr("addi_disabled",11'b10010001000, K_I,    3'd0, 1'b0, 0, 0, -1, 1'b1);
    runInstr("ldur_wait3",   11'b11111000010, K_LD,   3'd0, 1'b0, 0, 3, -1, 1'b0);
    runInstr("cbz_taken",    11'b10110100101, K_CBZ,  3'd4, 1'b1, 0, 0, -1, 1'b0);
    runInstr("cbnz_zero1",   11'b10110101011, K_CBNZ, 3'd4, 1'b1, 0, 0, -1, 1'b0);
    runInstr("cbz_zero0",    11'b10110100000, K_CBZ,  3'd4, 1'b0, 1, 0, -1, 1'b0);
    runInstr("cbnz_taken",   11'b10110101111, K_CBNZ, 3'd4, 1'b0, 0, 0, -1, 1'b0);
    runInstr("b_uncond",     11'b00010110011, K_B,    3'd0, 1'b0, 2, 0, -1, 1'b0);
    runInstr("illegal_zero", 11'b00000000000, K_ILL,  3'd0, 1'b0, 0, 0, -1, 1'b0);
    runInstr("stur_rstMem",  11'b11111000000, K_ST,   3'd0, 1'b0, 0, 5,  4, 1'b0);
    runInstr("after_rstMem", 11'b11001011000, K_R,    3'd1, 1'b0, 0, 0, -1, 1'b0);
    runInstr("fetch_lastRdy",11'b00010100001, K_B,    3'd0, 1'b0, WAIT_MAX - 1, 0, -1, 1'b0);
    runInstr("ldur_lastRdy", 11'b11111000010, K_LD,   3'd0, 1'b0, 0, WAIT_MAX - 1, -1, 1'b0);
    runInstr("stur_lastRdy", 11'b11111000000, K_ST,   3'd0, 1'b0, 0, WAIT_MAX - 1, -1, 1'b0);
    runInstr("fetch_timeout",11'b10001011000, K_R,    3'd0, 1'b0, WAIT_MAX, 0, -1, 1'b0);
    resetSeq("rst_fromHalt");
    runInstr("after_halt",   11'b10101010000, K_R,    3'd3, 1'b0, 0, 0, -1, 1'b0);
    runInstr("mem_timeout",  11'b11111000000, K_ST,   3'd0, 1'b0, 0, WAIT_MAX, -1, 1'b0);
    resetSeq("rst_fromMemHalt");

    repeat (150) begin
      idx = $urandom_range(0, 15);
      op  = tbl[idx].base | (11'($urandom) & tbl[idx].mask);
      iw  = ($urandom_range(0, 9) == 0) ? WAIT_MAX - 1 : $urandom_range(0, 3);
      dw  = ($urandom_range(0, 9) == 0) ? WAIT_MAX - 1 : $urandom_range(0, 3);
      runInstr(tbl[idx].name, op, tbl[idx].k, tbl[idx].alu, rb(), iw, dw, -1, 1'b0);
    end

    @(posedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (q1.size() + q2.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d records left, expected 0", q1.size() + q2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multicycle_cu.md
MULTICYCLE_CU -- requirements
Module: multicycle_cu

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- OPCODE_W, 11, opcode width; value 11 only in this release.
- WAIT_MAX, 15, max ready-wait cycles before timeout, range 1..255.
- ENABLE_IMM, 1, 1 = decode ADDI/SUBI/ANDI/ORRI; 0 = treat them as illegal.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock, rising edge.
- reset, in, 1, synchronous, active-high.
- opcode, in, OPCODE_W, instruction[31:21] from instruction memory.
- Zero, in, 1, ALU zero flag.
- imem_ready, in, 1, instruction fetch complete.
- dmem_ready, in, 1, data access complete.
- imemRd, out, 1, instruction memory read strobe.
- irWr, out, 1, IR load enable.
- reg2loc, out, 1, register-read-2 select.
- seu, out, 2, immediate-format select: 00 ALU-imm, 01 D, 10 B, 11 CB.
- aluSrc, out, 1, ALU B-input select: 1 = immediate.
- aluOp, out, 3, ALU operation: 000 add, 001 sub, 010 and, 011 orr, 100 pass-B.
- memRd, out, 1, data memory read strobe.
- memWr, out, 1, data memory write strobe.
- memToReg, out, 1, writeback source select: 1 = memory.
- regWr, out, 1, register file write enable.
- pcWr, out, 1, PC load enable.
- pcSrc, out, 1, PC source: 0 = PC+4, 1 = branch target.
- state_o, out, 3, current state encoding.
- illegal, out, 1, one-cycle pulse on an undecodable opcode.
- timeout, out, 1, sticky; ready-wait exceeded.
REQ-003 Clock and reset are fixed: one clock, clk; reset is synchronous and active-high.

Function
REQ-004 States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
REQ-005 Outputs are decoded from the state register and the latched opcode op_q only; no combinational path from opcode to any output.
REQ-006 FETCH:
- imemRd=1 every cycle while in FETCH.
- On imem_ready=1: irWr=1, pcWr=1, pcSrc=0, opcode captured into op_q, next state DECODE.
REQ-007 DECODE: lasts 1 cycle; classifies op_q; all strobes 0.
- Classes: R = ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
- I = op_q[10:1] in {1001000100, 1101000100, 1001001000, 1011001000}.
- D = LDUR 11111000010, STUR 11111000000.
- B = op_q[10:5]=000101.
- CB = op_q[10:3] in {10110100 CBZ, 10110101 CBNZ}.
- Match priority: full 11-bit match, then 10-bit, then 8-bit, then 6-bit.
REQ-008 Unmatched opcode in DECODE: illegal=1 for that cycle, next state FETCH; no register or memory write occurs.
REQ-009 EXEC, R class: reg2loc=0, aluSrc=0, aluOp per instruction (000/001/010/011); next WB.
REQ-010 EXEC, I class: reg2loc=1, seu=00, aluSrc=1, aluOp per instruction; next WB.
REQ-011 EXEC, D class: reg2loc=1, seu=01, aluSrc=1, aluOp=000; next MEM.
REQ-012 EXEC, B class: seu=10, pcWr=1, pcSrc=1; next FETCH.
REQ-013 EXEC, CB class: reg2loc=1, seu=11, aluOp=100.
- Branch taken when (CBZ and Zero=1) or (CBNZ and Zero=0).
- Taken: pcWr=1, pcSrc=1. Not taken: pcWr=0.
- Next FETCH either way.
REQ-014 MEM:
- Hold seu=01, aluSrc=1, aluOp=000.
- LDUR: memRd=1. STUR: memWr=1. Strobe held until dmem_ready=1.
- On dmem_ready: LDUR goes to WB; STUR goes to FETCH.
REQ-015 WB: regWr=1 for exactly 1 cycle; memToReg=1 for LDUR, 0 otherwise; next FETCH.
REQ-016 Wait counter:
- 8-bit; cleared on entry to FETCH or MEM; increments each cycle ready is low.
- If it reaches WAIT_MAX with ready still low: timeout=1, next HALT.
- A ready asserted on the WAIT_MAX cycle wins over timeout.
REQ-017 HALT: all strobes 0, state_o=7; exited only by reset.
REQ-018 Every output not driven by the current state is 0.
REQ-019 Latency with zero wait-states (cycles per instruction):
- R/I: 4.
- LDUR: 5.
- STUR: 4.
- B/CB: 3.

Reset
REQ-020 While reset=1 at a clock edge: state=FETCH, op_q=0, counter=0, timeout=0.
REQ-021 Outputs during the reset cycle: all strobes 0 and state_o=0.
REQ-022 First cycle after reset: imemRd=1.
REQ-023 A reset asserted in any state, including MEM with memWr=1 or HALT, takes effect at the next edge; memWr/regWr deassert in the following cycle.

Verification
REQ-024 ADD 10001011000, imem_ready and dmem_ready held 1:
- States 0,1,2,4,0.
- aluOp=000 in EXEC; regWr=1 only in WB.
REQ-025 LDUR 11111000010, dmem_ready low for 3 cycles:
- memRd=1 for 4 cycles.
- Then WB with regWr=1, memToReg=1.
REQ-026 CBZ 10110100xxx:
- Zero=1 in EXEC: pcWr=1, pcSrc=1.
- Repeat with CBNZ and Zero=1: pcWr=0.
REQ-027 Opcode 00000000000: illegal pulses in DECODE; no regWr/memWr; FETCH follows.
- Repeat ADDI with ENABLE_IMM=0: also illegal.
REQ-028 imem_ready held 0, WAIT_MAX=15:
- timeout=1 and state_o=7 after 15 FETCH cycles.
- reset then returns the block to FETCH with timeout=0.
REQ-029 STUR with reset asserted during MEM: memWr=0 in the cycle after the reset edge; state_o=0.
